cpu_sequencer: RTL and testbench

Control unit for the 4-bit nibble processor. Owns the 12-bit program counter and a fetch/execute state machine, decodes the opcode and operand held in the instruction fetch register, and drives the enables and select lines for the fetch register, accumulator, flags register, output port and ALU. It sits between the program ROM and the existing register blocks. It also provides a valid/ack handshake on the input port and a halt state.

---
 rtl/cpu_sequencer.sv | 170 +++++++++++++++++
 tb/tb_cpu_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: program counter and fetch/execute control for the 4-bit
// nibble processor. Drives the register enables and ALU select for the
// datapath, a valid/ack handshake on the input port, and a halt state.
// Optional feature macro: CPU_SEQ_ILLEGAL_TRAP_EN (trap opcodes 0xD/0xE).
module cpu_sequencer #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        clk,
  input  logic        R,
  input  logic [7:0]  rom_data,
  input  logic [3:0]  instr,
  input  logic [3:0]  oprnd,
  input  logic        cflag,
  input  logic        zflag,
  input  logic        in_valid,
  output logic [11:0] pc_addr,
  output logic        fetch_en,
  output logic        acc_en,
  output logic        flags_en,
  output logic        out_en,
  output logic        in_sel,
  output logic        in_ack,
  output logic [2:0]  alu_sel,
  output logic        phase,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    EXEC    = 2'd1,
    WAIT_IN = 2'd2,
    HALT    = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [11:0] pc, pc_nxt;
  logic        taken;
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
  logic        trap;
  logic        illegal_q;
`endif

  // Branch condition for the two-byte jump opcodes 0x8..0xC.
  always_comb begin
    taken = 1'b0;
    case (instr)
      4'h8:    taken = 1'b1;
      4'h9:    taken = cflag;
      4'hA:    taken = ~cflag;
      4'hB:    taken = zflag;
      4'hC:    taken = ~zflag;
      default: taken = 1'b0;
    endcase
  end

  // Next-state, next-pc and datapath controls; everything is held low during reset.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    fetch_en  = 1'b0;
    acc_en    = 1'b0;
    flags_en  = 1'b0;
    out_en    = 1'b0;
    in_sel    = 1'b0;
    in_ack    = 1'b0;
    alu_sel   = 3'b000;
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
    trap      = 1'b0;
`endif
    if (!R) begin
      case (state)
        FETCH: begin
          fetch_en  = 1'b1;
          pc_nxt    = pc + 12'd1;
          state_nxt = EXEC;
        end
        EXEC: begin
          state_nxt = FETCH;
          case (instr)
            4'h1: begin
              alu_sel  = 3'b000;
              acc_en   = 1'b1;
              flags_en = 1'b1;
            end
            4'h2: begin
              if (in_valid) begin
                acc_en = 1'b1;
                in_sel = 1'b1;
                in_ack = 1'b1;
              end else begin
                state_nxt = WAIT_IN;
              end
            end
            4'h3: out_en = 1'b1;
            4'h4: begin
              alu_sel  = 3'b001;
              acc_en   = 1'b1;
              flags_en = 1'b1;
            end
            4'h5: begin
              alu_sel  = 3'b010;
              acc_en   = 1'b1;
              flags_en = 1'b1;
            end
            4'h6: begin
              alu_sel  = 3'b011;
              acc_en   = 1'b1;
              flags_en = 1'b1;
            end
            4'h7: begin
              alu_sel  = 3'b010;
              flags_en = 1'b1;
            end
            // Second jump byte is already on rom_data since pc points at it.
            4'h8, 4'h9, 4'hA, 4'hB, 4'hC:
              pc_nxt = taken ? {oprnd, rom_data} : pc + 12'd1;
            4'hD, 4'hE: begin
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
              trap      = 1'b1;
              state_nxt = HALT;
`endif
            end
            4'hF: state_nxt = HALT;
            default: ;
          endcase
        end
        WAIT_IN: begin
          if (in_valid) begin
            acc_en    = 1'b1;
            in_sel    = 1'b1;
            in_ack    = 1'b1;
            state_nxt = FETCH;
          end
        end
        HALT: state_nxt = HALT;
        default: state_nxt = FETCH;
      endcase
    end
  end

  // State and program counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (R) begin
      state <= FETCH;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
  // Sticky illegal-opcode flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (R)
      illegal_q <= 1'b0;
    else if (trap)
      illegal_q <= 1'b1;
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  assign pc_addr = pc;
  assign phase   = (state != FETCH);
  assign halted  = (state == HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: a ROM array and the external fetch
// register surround the DUT; each step checks outputs 1 time unit after the edge.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        R = 1'b1;
  logic [7:0]  rom_data;
  logic [3:0]  instr = 4'h0;
  logic [3:0]  oprnd = 4'h0;
  logic        cflag = 1'b0;
  logic        zflag = 1'b0;
  logic        in_valid = 1'b0;
  logic [11:0] pc_addr;
  logic        fetch_en, acc_en, flags_en, out_en, in_sel, in_ack;
  logic [2:0]  alu_sel;
  logic        phase, halted, illegal;

  logic [7:0]  rom [4096];
  int          checks = 0;
  int          errors = 0;

  cpu_sequencer #(.RESET_PC(12'h000)) dut (
    .clk(clk), .R(R), .rom_data(rom_data), .instr(instr), .oprnd(oprnd),
    .cflag(cflag), .zflag(zflag), .in_valid(in_valid), .pc_addr(pc_addr),
    .fetch_en(fetch_en), .acc_en(acc_en), .flags_en(flags_en), .out_en(out_en),
    .in_sel(in_sel), .in_ack(in_ack), .alu_sel(alu_sel), .phase(phase),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign rom_data = rom[pc_addr];

  // External fetch register loaded from the ROM byte when enabled.
  always @(posedge clk) begin
    if (fetch_en) begin
      instr <= rom_data[7:4];
      oprnd <= rom_data[3:0];
    end
  end

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
  endtask

  // One reset edge, checking the post-reset state while R is still high.
  task automatic do_reset();
    R = 1'b1;
    step();
    chk("rst_pc", pc_addr, 12'h000);
    chk("rst_phase", {11'd0, phase}, 12'd0);
    chk("rst_halted", {11'd0, halted}, 12'd0);
    chk("rst_illegal", {11'd0, illegal}, 12'd0);
    chk("rst_enables", {6'd0, fetch_en, acc_en, flags_en, out_en, in_sel, in_ack}, 12'd0);
    R = 1'b0;
    #1;
  endtask

  initial begin
    // LIT 5, ADDI 3, OUT
    clear_rom();
    rom[0] = 8'h15; rom[1] = 8'h43; rom[2] = 8'h30;
    do_reset();
    chk("c0_fetch", {11'd0, fetch_en}, 12'd1);
    chk("c0_pc", pc_addr, 12'h000);
    step();
    chk("c1_pc", pc_addr, 12'h001);
    chk("c1_acc_flags", {10'd0, acc_en, flags_en}, 12'd3);
    chk("c1_alu", {9'd0, alu_sel}, 12'd0);
    chk("c1_phase", {11'd0, phase}, 12'd1);
    step();
    chk("c2_fetch", {11'd0, fetch_en}, 12'd1);
    chk("c2_pc", pc_addr, 12'h001);
    step();
    chk("c3_pc", pc_addr, 12'h002);
    chk("c3_acc", {11'd0, acc_en}, 12'd1);
    chk("c3_alu", {9'd0, alu_sel}, 12'd1);
    step();
    chk("c4_fetch", {11'd0, fetch_en}, 12'd1);
    chk("c4_pc", pc_addr, 12'h002);
    step();
    chk("c5_pc", pc_addr, 12'h003);
    chk("c5_out", {11'd0, out_en}, 12'd1);
    chk("c5_acc", {11'd0, acc_en}, 12'd0);

    // JMP 0x010, then JC 0xABC with carry set
    clear_rom();
    rom[0] = 8'h80; rom[1] = 8'h10; rom[12'h010] = 8'h9A; rom[12'h011] = 8'hBC;
    cflag = 1'b1;
    do_reset();
    step();
    chk("jmp_no_en", {7'd0, fetch_en, acc_en, flags_en, out_en, in_ack}, 12'd0);
    step();
    chk("jmp_target", pc_addr, 12'h010);
    step();
    step();
    chk("jc_taken_pc", pc_addr, 12'hABC);
    chk("jc_taken_phase", {11'd0, phase}, 12'd0);

    // Same JC with carry clear skips the second byte
    cflag = 1'b0;
    do_reset();
    step(); step(); step(); step();
    chk("jc_not_taken_pc", pc_addr, 12'h012);

    // IN: in_valid ignored under reset, then 3 WAIT_IN cycles
    clear_rom();
    rom[0] = 8'h20;
    R = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("in_ack_under_reset", {11'd0, in_ack}, 12'd0);
    in_valid = 1'b0;
    do_reset();
    step();
    chk("in_exec_no_ack", {10'd0, in_ack, acc_en}, 12'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_in_phase", {11'd0, phase}, 12'd1);
      chk("wait_in_no_en", {6'd0, fetch_en, acc_en, flags_en, out_en, in_sel, in_ack}, 12'd0);
      chk("wait_in_pc", pc_addr, 12'h001);
    end
    step();
    in_valid = 1'b1;
    #1;
    chk("in_accept", {9'd0, in_ack, acc_en, in_sel}, 12'd7);
    chk("in_accept_flags", {11'd0, flags_en}, 12'd0);
    step();
    in_valid = 1'b0;
    #1;
    chk("in_then_fetch", {10'd0, phase, fetch_en}, 12'd1);
    chk("in_ack_one_cycle", {11'd0, in_ack}, 12'd0);

    // NOP at 0xFFF wraps the pc
    clear_rom();
    rom[0] = 8'h8F; rom[1] = 8'hFF;
    do_reset();
    step(); step();
    chk("jmp_fff", pc_addr, 12'hFFF);
    step();
    chk("pc_wrap", pc_addr, 12'h000);

    // HALT is absorbing until reset
    clear_rom();
    rom[0] = 8'hF0;
    do_reset();
    step();
    for (int i = 0; i < 10; i++) begin
      step();
      chk("halt_halted", {11'd0, halted}, 12'd1);
      chk("halt_pc", pc_addr, 12'h001);
      chk("halt_no_fetch", {11'd0, fetch_en}, 12'd0);
    end
    R = 1'b1;
    step();
    chk("halt_exit_pc", pc_addr, 12'h000);
    chk("halt_exit_halted", {11'd0, halted}, 12'd0);
    chk("halt_exit_phase", {11'd0, phase}, 12'd0);
    R = 1'b0;

    // Reserved opcode 0xD
    clear_rom();
    rom[0] = 8'hD0;
    do_reset();
    step(); step();
`ifdef CPU_SEQ_ILLEGAL_TRAP_EN
    chk("op_d_halted", {11'd0, halted}, 12'd1);
    chk("op_d_illegal", {11'd0, illegal}, 12'd1);
`else
    chk("op_d_fetch", {10'd0, phase, fetch_en}, 12'd1);
    chk("op_d_pc", pc_addr, 12'h001);
    chk("op_d_illegal", {11'd0, illegal}, 12'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
